// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  // One extra bit: the shifted remainder can exceed WIDTH bits before the subtract.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_mag};

  always_comb begin
    rem_out = shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement signed division (default: unsigned).
//
// Handshake: start is sampled only in IDLE; an accepted start raises busy on the
// next edge; done pulses for exactly one cycle (state FIX) with results valid and
// held; start seen while busy or while done is high is dropped, not queued.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output div_state_e       state_dbg
);
  div_state_e       state, state_nx;
  logic [WIDTH-1:0] dvd_q, dvs_q, dvs_mag_q, rem_q, quo_q;
  logic [CNT_W-1:0] cnt;
  logic             neg_quo, neg_rem;

  logic             accept, prep_en, iter_en, last_iter, zero_fin, finish;
  logic             dvs_zero;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, rem_nx, quo_nx, fixed_q, fixed_r;
  logic             dvd_sign, dvs_sign;

  assign state_dbg = state;
  assign dvs_zero  = (dvs_q == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign dvd_sign = dvd_q[WIDTH-1];
  assign dvs_sign = dvs_q[WIDTH-1];
  assign dvd_mag  = dvd_sign ? -dvd_q : dvd_q;
  assign dvs_mag  = dvs_sign ? -dvs_q : dvs_q;
`else
  assign dvd_sign = 1'b0;
  assign dvs_sign = 1'b0;
  assign dvd_mag  = dvd_q;
  assign dvs_mag  = dvs_q;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs_mag (dvs_mag_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Signs are applied to the final iteration's output so results land on entry to FIX.
  assign fixed_q = neg_quo ? -quo_nx : quo_nx;
  assign fixed_r = neg_rem ? -rem_nx : rem_nx;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PREP;
      PREP:    state_nx = dvs_zero ? FIX : ITER;
      ITER:    if (cnt == CNT_W'(WIDTH-1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && start;
    prep_en   = (state == PREP);
    iter_en   = (state == ITER);
    last_iter = iter_en && (cnt == CNT_W'(WIDTH-1));
    zero_fin  = prep_en && dvs_zero;
    finish    = last_iter || zero_fin;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      dvs_mag_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt       <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
        busy  <= 1'b1;
      end
      if (prep_en) begin
        rem_q     <= '0;
        quo_q     <= dvd_mag;
        dvs_mag_q <= dvs_mag;
        cnt       <= '0;
        neg_quo   <= dvd_sign ^ dvs_sign;
        neg_rem   <= dvd_sign;
      end
      if (iter_en) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt + CNT_W'(1);
      end
      if (finish) begin
        busy      <= 1'b0;
        div_zero  <= zero_fin;
        quotient  <= zero_fin ? WIDTH'(DIV_ZERO_QUOT) : fixed_q;
        remainder <= zero_fin ? dvd_q : fixed_r;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboarded bench for seq_divider: directed handshake/latency cases plus random operands.
module tb_seq_divider;
  import div_pkg::*;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;
  div_state_e  state_dbg;

  logic [64:0] exp_q[$];
  int vectors;
  int miscompares;

  seq_divider dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a, 1'b1};
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0, 1'b0};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
`else
    q = a / b;
    r = a % b;
`endif
    return {q, r, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  // Waits one edge so a preceding FIX cycle clears, then presents start for one edge.
  // Returns #1 after the edge that sampled start (edge 1).
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [64:0] exp);
    exp_q.push_back(exp);
    @(posedge clock); #1;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clock); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
  endtask

  // Counts edges from k0 until done, noting whether busy stayed high beforehand.
  task automatic wait_done(input int k0, output logic [64:0] got, output int lat, output bit busy_ok);
    busy_ok = (busy === 1'b1);
    got = '0;
    lat = -1;
    for (int k = k0; k < k0 + 200; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin
        got = {quotient, remainder, div_zero};
        lat = k;
        return;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({busy, done, div_zero, quotient, remainder} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got b=%b d=%b z=%b q=%h r=%h required all zero",
               busy, done, div_zero, quotient, remainder);
    end
    vectors++;
    if (state_dbg !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state got %0d required %0d", state_dbg, IDLE);
    end
    @(negedge clock); clear_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [64:0] got, exp; int lat; bit bok;
    launch(32'd100, 32'd7, {32'd14, 32'd2, 1'b0});
    wait_done(2, got, lat, bok);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL basic_result got %h required %h", got, exp);
    end
    vectors++;
    if (lat !== 34) begin
      miscompares++;
      $display("FAIL basic_latency got %0d required 34", lat);
    end
    vectors++;
    if (bok !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy got busy_ok=%b busy_at_done=%b required 1/0", bok, busy);
    end
    @(posedge clock); #1;
    vectors++;
    if (done !== 1'b0 || state_dbg !== IDLE || quotient !== 32'd14) begin
      miscompares++;
      $display("FAIL basic_pulse got done=%b state=%0d q=%h required 0/IDLE/0000000e",
               done, state_dbg, quotient);
    end
  endtask

  task automatic test_sign_cases();
    logic [64:0] got, exp; int lat; bit bok;
    logic [31:0] a_t[4], b_t[4];
    logic [64:0] e_t[4];
`ifdef SEQ_DIVIDER_SIGNED_EN
    a_t[0] = -32'sd100;     b_t[0] = 32'd7;         e_t[0] = {32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    a_t[1] = 32'd100;       b_t[1] = -32'sd7;       e_t[1] = {32'hFFFF_FFF2, 32'd2, 1'b0};
    a_t[2] = 32'h8000_0000; b_t[2] = 32'hFFFF_FFFF; e_t[2] = {32'h8000_0000, 32'd0, 1'b0};
    a_t[3] = -32'sd7;       b_t[3] = -32'sd2;       e_t[3] = {32'd3, 32'hFFFF_FFFF, 1'b0};
`else
    a_t[0] = 32'hFFFF_FFFF; b_t[0] = 32'd2;         e_t[0] = {32'h7FFF_FFFF, 32'd1, 1'b0};
    a_t[1] = 32'h8000_0000; b_t[1] = 32'hFFFF_FFFF; e_t[1] = {32'd0, 32'h8000_0000, 1'b0};
    a_t[2] = 32'd3;         b_t[2] = 32'd10;        e_t[2] = {32'd0, 32'd3, 1'b0};
    a_t[3] = 32'hFFFF_FFFF; b_t[3] = 32'hFFFF_FFFF; e_t[3] = {32'd1, 32'd0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      launch(a_t[i], b_t[i], e_t[i]);
      wait_done(2, got, lat, bok);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp || lat !== 34) begin
        miscompares++;
        $display("FAIL sign_case%0d got %h lat=%0d required %h lat=34", i, got, lat, exp);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [64:0] got, exp; int lat; bit bok;
    launch(32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5, 1'b1});
    wait_done(2, got, lat, bok);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp || lat !== 2) begin
      miscompares++;
      $display("FAIL div_zero got %h lat=%0d required %h lat=2", got, lat, exp);
    end
    launch(32'd9, 32'd3, {32'd3, 32'd0, 1'b0});
    wait_done(2, got, lat, bok);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp || lat !== 34) begin
      miscompares++;
      $display("FAIL div_zero_clear got %h lat=%0d required %h lat=34", got, lat, exp);
    end
  endtask

  task automatic test_ignore_start();
    logic [64:0] got, exp; int lat; bit bok;
    launch(32'd100, 32'd7, {32'd14, 32'd2, 1'b0});
    repeat (8) @(posedge clock);
    #1;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(11, got, lat, bok);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp || lat !== 34 || bok !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_start got %h lat=%0d busy_ok=%b required %h lat=34 busy_ok=1",
               got, lat, bok, exp);
    end
  endtask

  task automatic test_mid_reset();
    logic [64:0] got, exp; int lat; bit bok; bit saw_done;
    logic [31:0] a, b;
    launch(32'd100, 32'd7, {32'd14, 32'd2, 1'b0});
    repeat (13) @(posedge clock);
    @(negedge clock); clear_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    vectors++;
    if ({busy, done, div_zero, quotient, remainder} !== 67'd0 || state_dbg !== IDLE) begin
      miscompares++;
      $display("FAIL mid_reset got b=%b d=%b z=%b q=%h r=%h state=%0d required zeros/IDLE",
               busy, done, div_zero, quotient, remainder, state_dbg);
    end
    @(negedge clock); clear_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_no_done got done seen=%b required 0", saw_done);
    end
    a = $urandom; b = $urandom_range(1, 1000);
    launch(a, b, model(a, b));
    wait_done(2, got, lat, bok);
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp || lat !== 34) begin
      miscompares++;
      $display("FAIL after_reset got %h lat=%0d required %h lat=34", got, lat, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] got, exp; int lat; bit bok;
    logic [31:0] a, b;
    a = 32'd1234567; b = 32'd89;
    launch(a, b, model(a, b));
    wait_done(2, got, lat, bok);
    for (int i = 0; i < 6; i++) begin
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp || lat !== 34) begin
        miscompares++;
        $display("FAIL back_to_back%0d got %h lat=%0d required %h lat=34", i, got, lat, exp);
      end
      // start raised while done is high must be dropped
      start = 1'b1; dividend = 32'd77; divisor = 32'd0;
      @(posedge clock); #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL start_in_fix%0d got busy=%b done=%b required 0/0", i, busy, done);
      end
      a = $urandom;
      case (i % 3)
        0:       b = $urandom_range(1, 15);
        1:       b = $urandom;
        default: b = $urandom_range(0, 3);
      endcase
      dividend = a; divisor = b;
      exp_q.push_back(model(a, b));
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(2, got, lat, bok);
      if (b == 32'd0) lat = lat + 32;
    end
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp || lat !== 34) begin
      miscompares++;
      $display("FAIL back_to_back_last got %h lat=%0d required %h lat=34", got, lat, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_sign_cases();
    test_div_zero();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
